// File: rtl/puzzle_draw_pkg.sv
// rtl/puzzle_draw_pkg.sv - shared types and constants for the puzzle board drawing stages
package puzzle_draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_GLYPH_RST,
        S_GLYPH,
        S_NEXT,
        S_DONE
    } draw_state_e;

    localparam int GRID_DEF      = 3;
    localparam int TILE_SIZE_DEF = 32;
    localparam int SLICE_W       = 4;
    localparam int BOARD_W       = GRID_DEF * GRID_DEF * SLICE_W;

    localparam logic [2:0] TILE_COLOUR  = 3'b111;
    localparam logic [2:0] BLANK_COLOUR = 3'b000;
    localparam logic [2:0] INK_COLOUR   = 3'b000;

    // Only 1..8 have a drawer; 0 and 9..15 are rendered as the blank tile.
    function automatic logic is_glyph(input logic [SLICE_W-1:0] v);
        return (v != 4'd0) && (v <= 4'd8);
    endfunction

endpackage

// File: rtl/tile_draw_sequencer_if.sv
// rtl/tile_draw_sequencer_if.sv - request/draw bus between sequencer, controller and drawers
// master: the sequencer (takes start/board, drives drawer and pixel signals)
// slave:  the controller / VGA mux side
interface tile_draw_sequencer_if;
    logic                             start;
    logic [puzzle_draw_pkg::BOARD_W-1:0] board;
    logic                             busy;
    logic                             done;
    logic [7:0]                       tile_x;
    logic [6:0]                       tile_y;
    logic [3:0]                       digit;
    logic                             glyph_enable;
    logic                             glyph_resetn;
    logic                             pix_sel;
    logic [7:0]                       fill_x;
    logic [6:0]                       fill_y;
    logic                             plot;
    logic [2:0]                       colour;

    modport master (
        input  start, board,
        output busy, done, tile_x, tile_y, digit, glyph_enable, glyph_resetn,
               pix_sel, fill_x, fill_y, plot, colour
    );

    modport slave (
        output start, board,
        input  busy, done, tile_x, tile_y, digit, glyph_enable, glyph_resetn,
               pix_sel, fill_x, fill_y, plot, colour
    );
endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - 2-D raster counter, fx fastest, last on final pixel
// Ports: clk, reset (sync active-high), clear_i (sync clear), enable_i (advance),
//        fx_o / fy_o (current pixel offset), last_o (fx = fy = SIZE-1)
module raster_counter #(
    parameter int SIZE = 32,
    parameter int W    = $clog2(SIZE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         enable_i,
    output logic [W-1:0] fx_o,
    output logic [W-1:0] fy_o,
    output logic         last_o
);
    localparam logic [W-1:0] MAX = W'(SIZE - 1);

    logic [W-1:0] fx_q;
    logic [W-1:0] fy_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            fx_q <= '0;
            fy_q <= '0;
        end else if (enable_i) begin
            if (fx_q == MAX) begin
                fx_q <= '0;
                fy_q <= (fy_q == MAX) ? '0 : fy_q + 1'b1;
            end else begin
                fx_q <= fx_q + 1'b1;
            end
        end
    end

    assign fx_o   = fx_q;
    assign fy_o   = fy_q;
    assign last_o = (fx_q == MAX) && (fy_q == MAX);

endmodule

// File: rtl/tile_draw_sequencer.sv
// rtl/tile_draw_sequencer.sv - walks the 3x3 board: background fill then digit drawer per tile
// Ports: clk, reset (sync active-high), bus (master): start/board in;
//        busy, done, tile_x/tile_y, digit, glyph_enable, glyph_resetn,
//        pix_sel, fill_x/fill_y, plot, colour out
module tile_draw_sequencer
    import puzzle_draw_pkg::*;
#(
    parameter int GRID         = GRID_DEF,
    parameter int TILE_SIZE    = TILE_SIZE_DEF,
    parameter int BOARD_X0     = 16,
    parameter int BOARD_Y0     = 12,
    parameter int GLYPH_CYCLES = 101
) (
    input  logic                  clk,
    input  logic                  reset,
    tile_draw_sequencer_if.master bus
);
    localparam int NUM_TILES = GRID * GRID;
    localparam int RW        = $clog2(TILE_SIZE);

    draw_state_e          state_q, state_d;
    logic [BOARD_W-1:0]   board_q;
    logic [3:0]           idx_q;
    logic [3:0]           col_q;
    logic [3:0]           digit_q;
    logic [7:0]           tile_x_q;
    logic [6:0]           tile_y_q;
    logic [6:0]           gcount_q;
    logic [3:0]           idx_nx;
    logic [RW-1:0]        fx, fy;
    logic                 fill_last;
    logic                 glyph_tile;
    logic                 last_tile;
    logic                 glyph_last;

    raster_counter #(.SIZE(TILE_SIZE), .W(RW)) u_raster (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != S_FILL),
        .enable_i (state_q == S_FILL),
        .fx_o     (fx),
        .fy_o     (fy),
        .last_o   (fill_last)
    );

    assign idx_nx     = idx_q + 4'd1;
    assign glyph_tile = is_glyph(digit_q);
    assign last_tile  = (idx_q == 4'(NUM_TILES - 1));
    assign glyph_last = (gcount_q == 7'(GLYPH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.start) state_d = S_LOAD;
            S_LOAD:      state_d = S_FILL;
            S_FILL:      if (fill_last) state_d = glyph_tile ? S_GLYPH_RST : S_NEXT;
            S_GLYPH_RST: state_d = S_GLYPH;
            S_GLYPH:     if (glyph_last) state_d = S_NEXT;
            S_NEXT:      state_d = last_tile ? S_DONE : S_FILL;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Tile origin is stepped by adders as the walk advances; digit is looked
    // up one tile ahead so it is valid from the first FILL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            board_q  <= '0;
            idx_q    <= '0;
            col_q    <= '0;
            digit_q  <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
            gcount_q <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    board_q  <= bus.board;
                    idx_q    <= '0;
                    col_q    <= '0;
                    digit_q  <= bus.board[SLICE_W-1:0];
                    tile_x_q <= 8'(BOARD_X0);
                    tile_y_q <= 7'(BOARD_Y0);
                end
                S_GLYPH_RST: gcount_q <= '0;
                S_GLYPH:     gcount_q <= gcount_q + 7'd1;
                S_NEXT: begin
                    if (!last_tile) begin
                        idx_q   <= idx_nx;
                        digit_q <= board_q[{idx_nx, 2'b00} +: SLICE_W];
                        if (col_q == 4'(GRID - 1)) begin
                            col_q    <= '0;
                            tile_x_q <= 8'(BOARD_X0);
                            tile_y_q <= tile_y_q + 7'(TILE_SIZE);
                        end else begin
                            col_q    <= col_q + 4'd1;
                            tile_x_q <= tile_x_q + 8'(TILE_SIZE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.tile_x       = tile_x_q;
    assign bus.tile_y       = tile_y_q;
    assign bus.digit        = digit_q;
    assign bus.glyph_enable = (state_q == S_GLYPH);
    // Drawers are held in reset while idle and pulsed for one cycle before each glyph.
    assign bus.glyph_resetn = (state_q != S_IDLE) && (state_q != S_GLYPH_RST);
    assign bus.pix_sel      = (state_q == S_GLYPH);
    assign bus.plot         = (state_q == S_FILL) || (state_q == S_GLYPH);
    assign bus.fill_x       = tile_x_q + 8'(fx);
    assign bus.fill_y       = tile_y_q + 7'(fy);
    assign bus.colour       = (state_q == S_FILL)  ? (glyph_tile ? TILE_COLOUR : BLANK_COLOUR) :
                              (state_q == S_GLYPH) ? INK_COLOUR : 3'b000;

endmodule
